// File: rtl/mvu_apb_csr_bridge_if.sv
// APB completer-side bus bundle for the MVU CSR bridge.
// The master modport drives requests, and the slave modport returns ready, read data and error.
interface mvu_apb_csr_bridge_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) ();
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic                  pready;
    logic [DATA_W-1:0]     prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/mvu_apb_csr_bridge.sv
// APB-to-CSR bridge for the MVU array. It forwards CSR accesses to the selected MVU,
// pulses a start on COMMAND writes and serves STATUS locally. Define MVU_APB_STRB_EN to honour pstrb.
module mvu_apb_csr_bridge #(
    parameter int APB_ADDR_WIDTH = 15,
    parameter int APB_DATA_WIDTH = 32,
    parameter int NMVU           = 8,
    parameter int CSR_RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    mvu_apb_csr_bridge_if.slave            apb,
    output logic [$clog2(NMVU)-1:0]        csr_sel,
    output logic [11:0]                    csr_addr,
    output logic                           csr_we,
    output logic                           csr_re,
    output logic [APB_DATA_WIDTH-1:0]      csr_wdata,
    output logic [APB_DATA_WIDTH/8-1:0]    csr_wstrb,
    input  logic [NMVU*APB_DATA_WIDTH-1:0] csr_rdata,
    input  logic [NMVU-1:0]                mvu_busy,
    output logic [NMVU-1:0]                mvu_start
);
    localparam int SEL_W  = $clog2(NMVU);
    localparam int STRB_W = APB_DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(CSR_RD_LATENCY + 1);

    localparam logic [11:0] CSR_LO      = 12'hF20;
    localparam logic [11:0] CSR_HI      = 12'hF69;
    localparam logic [11:0] CSR_STATUS  = 12'hF54;
    localparam logic [11:0] CSR_COMMAND = 12'hF55;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                     state_r, state_s;
    logic [SEL_W-1:0]           sel_r;
    logic [11:0]                addr_r;
    logic                       write_r;
    logic [APB_DATA_WIDTH-1:0]  wdata_r;
    logic [STRB_W-1:0]          wstrb_r;
    logic [CNT_W-1:0]           cnt_r;
    logic [APB_DATA_WIDTH-1:0]  prdata_r;

    logic [APB_ADDR_WIDTH-1:0]  paddr_s;
    logic                       setup_s;
    logic                       err_s;
    logic                       wr_ok_s;
    logic                       start_ok_s;
    logic [APB_DATA_WIDTH-1:0]  lane_s;
    logic                       capture_s;
    logic                       pready_s;
    logic                       pslverr_s;
    logic [APB_DATA_WIDTH-1:0]  prdata_s;
    logic                       we_s;
    logic                       re_s;
    logic [NMVU-1:0]            start_s;

    assign paddr_s = apb.paddr;
    assign setup_s = apb.psel && !apb.penable;
    assign lane_s  = csr_rdata[int'(sel_r) * APB_DATA_WIDTH +: APB_DATA_WIDTH];

    // STATUS is read-only, so writing it is an error just like an out-of-range access.
    assign err_s = (addr_r < CSR_LO) || (addr_r > CSR_HI) || (write_r && (addr_r == CSR_STATUS));

`ifdef MVU_APB_STRB_EN
    assign wr_ok_s    = (wstrb_r != {STRB_W{1'b0}});
    assign start_ok_s = wstrb_r[0];
`else
    assign wr_ok_s    = 1'b1;
    assign start_ok_s = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transfer latches, read-latency counter and captured read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r    <= {SEL_W{1'b0}};
            addr_r   <= 12'h000;
            write_r  <= 1'b0;
            wdata_r  <= {APB_DATA_WIDTH{1'b0}};
            wstrb_r  <= {STRB_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            prdata_r <= {APB_DATA_WIDTH{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && setup_s) begin
                sel_r   <= paddr_s[12 +: SEL_W];
                addr_r  <= paddr_s[11:0];
                write_r <= apb.pwrite;
                wdata_r <= apb.pwdata;
`ifdef MVU_APB_STRB_EN
                wstrb_r <= apb.pstrb;
`else
                wstrb_r <= {STRB_W{1'b1}};
`endif
            end
            if (state_r == ST_ISSUE) begin
                cnt_r <= CNT_W'(CSR_RD_LATENCY);
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            if (capture_s) begin
                prdata_r <= lane_s;
            end
        end
    end

    // Next-state and bus outputs; a dropped psel abandons the transfer without a response.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = {APB_DATA_WIDTH{1'b0}};
        we_s      = 1'b0;
        re_s      = 1'b0;
        start_s   = {NMVU{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (setup_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_IDLE;
                if (!apb.psel) begin
                    state_s = ST_IDLE;
                end else if (err_s) begin
                    pready_s  = 1'b1;
                    pslverr_s = 1'b1;
                end else if (write_r) begin
                    pready_s = 1'b1;
                    we_s     = wr_ok_s;
                    if ((addr_r == CSR_COMMAND) && wr_ok_s && start_ok_s) begin
                        start_s = {{(NMVU-1){1'b0}}, 1'b1} << sel_r;
                    end else begin
                        start_s = {NMVU{1'b0}};
                    end
                end else if (addr_r == CSR_STATUS) begin
                    pready_s = 1'b1;
                    prdata_s = {{(APB_DATA_WIDTH-1){1'b0}}, mvu_busy[sel_r]};
                end else begin
                    re_s    = 1'b1;
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!apb.psel) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    capture_s = 1'b1;
                    state_s   = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
                if (apb.psel) begin
                    pready_s = 1'b1;
                    prdata_s = prdata_r;
                end else begin
                    pready_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign apb.pready  = pready_s;
    assign apb.pslverr = pslverr_s;
    assign apb.prdata  = prdata_s;
    assign csr_we      = we_s;
    assign csr_re      = re_s;
    assign mvu_start   = start_s;
    assign csr_sel     = sel_r;
    assign csr_addr    = addr_r;
    assign csr_wdata   = wdata_r;
    assign csr_wstrb   = wstrb_r;
endmodule

// File: tb/tb_mvu_apb_csr_bridge.sv
// Self-checking bench for mvu_apb_csr_bridge: directed vector table, multi-cycle corner sequences
// and randomized transfers checked against a behavioural model of the address map.
module tb_mvu_apb_csr_bridge;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    csr_sel;
    logic [11:0]   csr_addr;
    logic          csr_we;
    logic          csr_re;
    logic [31:0]   csr_wdata;
    logic [3:0]    csr_wstrb;
    logic [255:0]  csr_rdata;
    logic [7:0]    mvu_busy;
    logic [7:0]    mvu_start;
    logic [31:0]   lane [8];

    int n_checks = 0;
    int n_pass   = 0;
    int proto_viol = 0;

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [7:0]  busy;
        logic        e_err;
        logic [31:0] e_prdata;
        int          e_cycles;
        logic        e_we;
        logic        e_re;
        logic [7:0]  e_start;
    } vec_t;

    vec_t vecs[14];

    mvu_apb_csr_bridge_if #(.ADDR_W(15), .DATA_W(32)) apb ();

    mvu_apb_csr_bridge #(
        .APB_ADDR_WIDTH(15),
        .APB_DATA_WIDTH(32),
        .NMVU(8),
        .CSR_RD_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .apb(apb),
        .csr_sel(csr_sel),
        .csr_addr(csr_addr),
        .csr_we(csr_we),
        .csr_re(csr_re),
        .csr_wdata(csr_wdata),
        .csr_wstrb(csr_wstrb),
        .csr_rdata(csr_rdata),
        .mvu_busy(mvu_busy),
        .mvu_start(mvu_start)
    );

    always #5 clk = ~clk;

    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < 8; i++) csr_rdata[32*i +: 32] = lane[i];
    end

    // Continuous protocol checks: gated read data/error, one-hot start coincident with write response
    always @(negedge clk) begin
        if (!rst) begin
            if (!apb.pready && (apb.prdata !== 32'h0 || apb.pslverr !== 1'b0)) proto_viol++;
            if ($countones(mvu_start) > 1) proto_viol++;
            if (mvu_start !== 8'h00 && !(apb.pready && csr_we)) proto_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t e;
        logic [11:0] csr;
        int m;
        e = v;
        csr = v.addr[11:0];
        m = int'(v.addr[14:12]);
        e.e_err = 1'b0; e.e_prdata = 32'h0; e.e_cycles = 1;
        e.e_we = 1'b0; e.e_re = 1'b0; e.e_start = 8'h00;
        if (csr < 12'hF20 || csr > 12'hF69 || (v.wr && csr == 12'hF54)) begin
            e.e_err = 1'b1;
        end else if (v.wr) begin
`ifdef MVU_APB_STRB_EN
            e.e_we = (v.strb != 4'h0);
            if (csr == 12'hF55 && v.strb[0]) e.e_start = 8'h01 << m;
`else
            e.e_we = 1'b1;
            if (csr == 12'hF55) e.e_start = 8'h01 << m;
`endif
        end else if (csr == 12'hF54) begin
            e.e_prdata = {31'h0, v.busy[m]};
        end else begin
            e.e_re = 1'b1;
            e.e_cycles = LAT + 2;
            e.e_prdata = lane[m];
        end
        return e;
    endfunction

    // Runs one transfer starting at posedge+1; leaves the bus idle at posedge+1 after pready.
    task automatic xfer(input vec_t v, input string tag);
        int cyc, we_n, re_n, st_n;
        logic done, slv;
        logic [7:0] st_or;
        logic [31:0] prd, wd1;
        logic [2:0] sel1;
        logic [11:0] addr1;
        logic [3:0] ws1, e_ws;
        cyc = 0; we_n = 0; re_n = 0; st_n = 0; st_or = 8'h00;
        done = 1'b0; slv = 1'b0; prd = 32'h0;
        sel1 = 3'h0; addr1 = 12'h0; wd1 = 32'h0; ws1 = 4'h0;
        mvu_busy = v.busy;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = v.wr;
        apb.paddr = v.addr; apb.pwdata = v.wdata; apb.pstrb = v.strb;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        while (!done && cyc < 16) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                sel1 = csr_sel; addr1 = csr_addr; wd1 = csr_wdata; ws1 = csr_wstrb;
            end
            if (csr_we) we_n++;
            if (csr_re) re_n++;
            if (mvu_start != 8'h00) begin st_n++; st_or = st_or | mvu_start; end
            if (apb.pready) begin done = 1'b1; prd = apb.prdata; slv = apb.pslverr; end
            @(posedge clk); #1;
        end
        apb.psel = 1'b0; apb.penable = 1'b0;
`ifdef MVU_APB_STRB_EN
        e_ws = v.strb;
`else
        e_ws = 4'hF;
`endif
        chk({tag, ".done"}, {31'h0, done}, 32'h1);
        chk({tag, ".cycles"}, cyc, v.e_cycles);
        chk({tag, ".pslverr"}, {31'h0, slv}, {31'h0, v.e_err});
        chk({tag, ".prdata"}, prd, v.e_prdata);
        chk({tag, ".we_count"}, we_n, {31'h0, v.e_we});
        chk({tag, ".re_count"}, re_n, {31'h0, v.e_re});
        chk({tag, ".start"}, {24'h0, st_or}, {24'h0, v.e_start});
        chk({tag, ".start_cycles"}, st_n, (v.e_start != 8'h00) ? 32'd1 : 32'd0);
        chk({tag, ".csr_sel"}, {29'h0, sel1}, {29'h0, v.addr[14:12]});
        chk({tag, ".csr_addr"}, {20'h0, addr1}, {20'h0, v.addr[11:0]});
        chk({tag, ".csr_wdata"}, wd1, v.wdata);
        chk({tag, ".csr_wstrb"}, {28'h0, ws1}, {28'h0, e_ws});
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, ".pready"}, {31'h0, apb.pready}, 32'h0);
        chk({tag, ".pslverr"}, {31'h0, apb.pslverr}, 32'h0);
        chk({tag, ".prdata"}, apb.prdata, 32'h0);
        chk({tag, ".csr_we"}, {31'h0, csr_we}, 32'h0);
        chk({tag, ".csr_re"}, {31'h0, csr_re}, 32'h0);
        chk({tag, ".mvu_start"}, {24'h0, mvu_start}, 32'h0);
        chk({tag, ".csr_sel"}, {29'h0, csr_sel}, 32'h0);
        chk({tag, ".csr_addr"}, {20'h0, csr_addr}, 32'h0);
        chk({tag, ".csr_wdata"}, csr_wdata, 32'h0);
        chk({tag, ".csr_wstrb"}, {28'h0, csr_wstrb}, 32'h0);
    endtask

    initial begin
        vec_t r;
        int pr_n;
        logic [11:0] rc;
        for (int i = 0; i < 8; i++) lane[i] = 32'hA0A0_0000 | i;
        lane[3] = 32'hDEAD_BEEF;
        lane[0] = 32'hC0DE_0F69;
        // wr, addr, wdata, strb, busy, err, prdata, cycles, we, re, start
        vecs[0]  = '{1'b1, 15'h2F20, 32'h0000_0123, 4'hF, 8'h00, 1'b0, 32'h0, 1, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 15'h5F55, 32'h0000_00A5, 4'hF, 8'h00, 1'b0, 32'h0, 1, 1'b1, 1'b0, 8'h20};
        vecs[2]  = '{1'b0, 15'h3F25, 32'h0, 4'hF, 8'h00, 1'b0, 32'hDEAD_BEEF, LAT+2, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 15'h7F54, 32'h0, 4'hF, 8'h80, 1'b0, 32'h1, 1, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 15'h7F54, 32'h55, 4'hF, 8'h80, 1'b1, 32'h0, 1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 15'h0F1F, 32'h0, 4'hF, 8'h00, 1'b1, 32'h0, 1, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 15'h0F6A, 32'h77, 4'hF, 8'h00, 1'b1, 32'h0, 1, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 15'h0F69, 32'h0, 4'hF, 8'h00, 1'b0, 32'hC0DE_0F69, LAT+2, 1'b0, 1'b1, 8'h00};
        vecs[8]  = '{1'b0, 15'h1F54, 32'h0, 4'hF, 8'h80, 1'b0, 32'h0, 1, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 15'h0F1F, 32'h9, 4'hF, 8'h00, 1'b1, 32'h0, 1, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 15'h6F54, 32'h0, 4'hF, 8'h40, 1'b0, 32'h1, 1, 1'b0, 1'b0, 8'h00};
`ifdef MVU_APB_STRB_EN
        vecs[11] = '{1'b1, 15'h1F55, 32'h1, 4'h0, 8'h00, 1'b0, 32'h0, 1, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 15'h0F55, 32'h1, 4'h2, 8'h00, 1'b0, 32'h0, 1, 1'b1, 1'b0, 8'h00};
`else
        vecs[11] = '{1'b1, 15'h1F55, 32'h1, 4'h0, 8'h00, 1'b0, 32'h0, 1, 1'b1, 1'b0, 8'h02};
        vecs[12] = '{1'b1, 15'h0F55, 32'h1, 4'h2, 8'h00, 1'b0, 32'h0, 1, 1'b1, 1'b0, 8'h01};
`endif
        vecs[13] = '{1'b1, 15'h4F69, 32'hCAFE_F00D, 4'hF, 8'h00, 1'b0, 32'h0, 1, 1'b1, 1'b0, 8'h00};

        rst = 1'b1; mvu_busy = 8'h00;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = 15'h0; apb.pwdata = 32'h0; apb.pstrb = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) xfer(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted during WAIT of a read
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 15'h3F25;
        @(posedge clk); #1; apb.penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        reset_outputs_zero("rst_in_wait");
        @(posedge clk); #1;
        rst = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0;
        @(posedge clk); #1;
        xfer('{1'b1, 15'h1F55, 32'h1, 4'hF, 8'h00, 1'b0, 32'h0, 1, 1'b1, 1'b0, 8'h02}, "after_rst");

        // psel dropped in WAIT: csr_re already issued, no pready afterwards
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 15'h3F25;
        @(posedge clk); #1; apb.penable = 1'b1;
        @(negedge clk);
        chk("drop_wait.csr_re", {31'h0, csr_re}, 32'h1);
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
        pr_n = 0;
        repeat (3) begin @(negedge clk); if (apb.pready) pr_n++; end
        chk("drop_wait.pready_count", pr_n, 0);
        @(posedge clk); #1;

        // psel dropped in ISSUE of a COMMAND write: no start, no response
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 15'h5F55;
        apb.pstrb = 4'hF;
        @(posedge clk); #1;
        apb.psel = 1'b0;
        @(negedge clk);
        chk("drop_issue.mvu_start", {24'h0, mvu_start}, 32'h0);
        chk("drop_issue.pready", {31'h0, apb.pready}, 32'h0);
        chk("drop_issue.csr_we", {31'h0, csr_we}, 32'h0);
        @(posedge clk); #1;
        xfer(vecs[2], "after_drop");

        // Randomized back-to-back transfers against the model
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 8; i++) lane[i] = $urandom;
            case ($urandom_range(0, 9))
                0: rc = 12'($urandom);
                1: rc = 12'hF54;
                2: rc = 12'hF55;
                default: rc = 12'($urandom_range(32'hF1C, 32'hF6E));
            endcase
            r.wr    = 1'($urandom);
            r.addr  = {3'($urandom_range(0, 7)), rc};
            r.wdata = $urandom;
            r.strb  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            r.busy  = 8'($urandom);
            r = model(r);
            xfer(r, $sformatf("rand%0d", n));
        end

        chk("protocol_violations", proto_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mvu_apb_csr_bridge.md
Name: mvu_apb_csr_bridge

Overview:
- APB completer that terminates the host's APB transfers to the MVU array.
- Splits paddr into an MVU index (paddr[14:12]) and a 12-bit CSR address (paddr[11:0]).
- Forwards writes and reads to the selected MVU's CSR port, pulses a one-hot start on writes to CSR_MVUCOMMAND, and serves CSR_MVUSTATUS locally from per-MVU busy flags.
- Sits between the APB interconnect and the NMVU CSR banks.

Parameters:
APB_ADDR_WIDTH, 15, APB address width (NMVU x 4KB CSR space)
APB_DATA_WIDTH, 32, APB/CSR data width
NMVU, 8, number of MVUs; the MVU index is $clog2(NMVU) bits
CSR_RD_LATENCY, 1, cycles from csr_re to valid csr_rdata (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  APB_ADDR_WIDTH  APB address
pwdata  in  APB_DATA_WIDTH  APB write data
pstrb  in  APB_DATA_WIDTH/8  APB byte strobes
pready  out  1  APB ready
prdata  out  APB_DATA_WIDTH  APB read data
pslverr  out  1  APB error
csr_sel  out  $clog2(NMVU)  target MVU index
csr_addr  out  12  target CSR address
csr_we  out  1  CSR write pulse
csr_re  out  1  CSR read pulse
csr_wdata  out  APB_DATA_WIDTH  CSR write data
csr_wstrb  out  APB_DATA_WIDTH/8  CSR byte strobes
csr_rdata  in  NMVU*APB_DATA_WIDTH  per-MVU read data, MVU i at [32i+:32]
mvu_busy  in  NMVU  per-MVU busy flag
mvu_start  out  NMVU  one-hot start pulse

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; the latched address/data registers are cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On psel=1 and penable=0, latch paddr, pwrite, pwdata and pstrb, then go to ISSUE.
  - pready=0.
- Address decode (on the latched paddr):
  - Legal CSR range is 0xF20..0xF69 inclusive.
  - Outside that range -> error.
  - A write to 0xF54 (STATUS) -> error.
- ISSUE (first access cycle):
  - Error: pready=1, pslverr=1, prdata=0, no csr_we/csr_re -> IDLE.
  - Write: csr_we=1 for exactly this cycle; pready=1, pslverr=0 (zero wait states) -> IDLE.
    - If csr_addr=0xF55, mvu_start[csr_sel]=1 in the same cycle.
  - Read of 0xF54: pready=1, prdata={31'b0, mvu_busy[csr_sel]} -> IDLE; no csr_re.
  - Other read: csr_re=1 for this cycle; load the down-counter with CSR_RD_LATENCY -> WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, register csr_rdata[32*csr_sel +: 32] into prdata -> RESP.
- RESP: pready=1, pslverr=0, prdata valid -> IDLE.
- Total read access phase is CSR_RD_LATENCY+2 cycles; pready is high only in the last of them.
- csr_sel, csr_addr, csr_wdata and csr_wstrb hold their latched values from ISSUE through RESP; they are don't-care in IDLE but do not glitch.
- prdata and pslverr are 0 whenever pready=0.
- psel drops during ISSUE/WAIT/RESP (protocol violation): go to IDLE the next cycle. No pready and no start pulse are issued. A csr_re already issued is not retracted.
- Back-to-back transfers: a new setup phase is accepted in the cycle after pready; no idle cycle is required beyond APB's own setup phase.
- mvu_start is never multi-hot and never wider than one cycle.
- Reset asserted mid-transfer: the transfer is abandoned and no pulse is emitted after reset.

Optional Feature:
- Macro MVU_APB_STRB_EN.
- Defined:
  - csr_wstrb=pstrb.
  - A write with pstrb=0 completes (pready=1, pslverr=0) without csr_we or mvu_start.
  - mvu_start requires pstrb[0]=1.
- Undefined: pstrb is ignored, csr_wstrb is forced to all-ones, and every legal write pulses csr_we.

Test Plan:
- Write 0x00000123 to paddr 0x2F20 -> ISSUE cycle: csr_sel=2, csr_addr=0xF20, csr_we=1, csr_wdata=0x123, pready=1, pslverr=0; no mvu_start.
- Write to paddr 0x5F55 -> mvu_start=8'b0010_0000 for one cycle, coincident with csr_we and pready.
- Read paddr 0x3F25 with csr_rdata MVU3=0xDEADBEEF, CSR_RD_LATENCY=1 -> csr_re in the first access cycle; pready=1 and prdata=0xDEADBEEF in the third access cycle.
- Read paddr 0x7F54 with mvu_busy=8'h80 -> pready in the first access cycle, prdata=0x00000001, no csr_re. Write to 0x7F54 -> pslverr=1, no csr_we.
- Accesses to paddr 0x0F1F and 0x0F6A -> pready=1, pslverr=1, prdata=0, no csr_we/csr_re. A read of 0x0F69 succeeds.
- Assert rst during WAIT of a read -> all outputs 0 immediately, no pready. A following write to 0x1F55 pulses mvu_start=8'h02 normally. With MVU_APB_STRB_EN, the same write with pstrb=0 gives pready=1 and no csr_we/mvu_start.
